// File: rtl/image_roi_copy.sv
`default_nettype none
//============================================================================
//  Module   : image_roi_copy
//  Purpose  : Pipelined BRAM-to-BRAM copy engine. Moves a rectangular region
//             of interest from a source frame buffer to a destination frame
//             buffer, one pixel per clock, with independent base addresses
//             and line strides on each side.
//
//  Parameters
//    AW      address width of both BRAM ports and all address/size inputs
//    DW      pixel width
//    RD_LAT  source BRAM read latency in cycles (1..7)
//
//  Ports
//    clk, rst_n        clock, asynchronous active-low reset
//    start             one-cycle launch pulse (honoured only when idle)
//    abort             level, cancels an active copy without a done pulse
//    cfg_src_base      source address of ROI pixel (0,0)
//    cfg_dst_base      destination address of ROI pixel (0,0)
//    cfg_src_stride    source words per line
//    cfg_dst_stride    destination words per line
//    cfg_w, cfg_h      ROI width / height
//    src_addr, src_en  source read port
//    src_data          source read data, valid RD_LAT cycles after src_en
//    dst_addr, dst_data, dst_en, dst_we   destination write port
//    busy              high from the cycle after an accepted start
//    done              one-cycle completion pulse
//
//  Optional build macro
//    ROI_THRESHOLD_EN  adds cfg_thr_en / cfg_thr inputs; when enabled the
//                      written pixel is binarised against cfg_thr.
//
//  Revision : 1.0  initial release
//============================================================================
module image_roi_copy #(
  parameter int AW     = 16,
  parameter int DW     = 4,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] cfg_src_base,
  input  logic [AW-1:0] cfg_dst_base,
  input  logic [AW-1:0] cfg_src_stride,
  input  logic [AW-1:0] cfg_dst_stride,
  input  logic [AW-1:0] cfg_w,
  input  logic [AW-1:0] cfg_h,
`ifdef ROI_THRESHOLD_EN
  input  logic          cfg_thr_en,
  input  logic [DW-1:0] cfg_thr,
`endif
  output logic [AW-1:0] src_addr,
  output logic          src_en,
  input  logic [DW-1:0] src_data,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data,
  output logic          dst_en,
  output logic          dst_we,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] c_one = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Configuration captured at launch; later cfg changes are not seen.
  logic [AW-1:0] r_w;
  logic [AW-1:0] r_h;
  logic [AW-1:0] r_src_stride;
  logic [AW-1:0] r_dst_stride;

  // Raster position of the read currently presented on src_addr, plus the
  // line bases and the destination address that belongs to that read.
  logic [AW-1:0] r_x;
  logic [AW-1:0] r_y;
  logic [AW-1:0] r_src_line;
  logic [AW-1:0] r_dst_line;
  logic [AW-1:0] r_dst_cur;

  // Valid / destination-address pipe matching the BRAM read latency.
  logic [RD_LAT-1:0] r_vld;
  logic [AW-1:0]     r_apipe [RD_LAT];

  logic [DW-1:0] w_pix;
  logic          w_launch;
  logic          w_empty_done;
  logic          w_line_end;
  logic          w_last_rd;
  logic          w_finish;
  logic          w_issue;
  logic          w_kill;

`ifdef ROI_THRESHOLD_EN
  logic          r_thr_en;
  logic [DW-1:0] r_thr;
`endif

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_empty_done = 1'b0;
    w_last_rd    = 1'b0;
    w_finish     = 1'b0;
    w_line_end   = (r_x == (r_w - c_one));

    case (r_state)
      S_IDLE: begin
        // abort has priority over a coincident start
        if (start && !abort) begin
          if ((cfg_w != '0) && (cfg_h != '0)) begin
            w_state_nxt = S_RUN;
            w_launch    = 1'b1;
          end else begin
            // empty ROI: acknowledge immediately, touch no memory
            w_empty_done = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_line_end && (r_y == (r_h - c_one))) begin
          // the read on src_addr this cycle is the final (w-1, h-1) pixel
          w_state_nxt = S_DRAIN;
          w_last_rd   = 1'b1;
        end
      end

      S_DRAIN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (~|r_vld) begin
          // pipe empty: the last write is on the destination port right now,
          // so done lands in the cycle after it
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Another read follows the current one only if we stay in RUN.
  assign w_issue = (r_state == S_RUN) && (w_state_nxt == S_RUN);
  assign w_kill  = abort && (r_state != S_IDLE);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Read-side address generation and status outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_en       <= 1'b0;
      src_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      r_w          <= '0;
      r_h          <= '0;
      r_src_stride <= '0;
      r_dst_stride <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_src_line   <= '0;
      r_dst_line   <= '0;
      r_dst_cur    <= '0;
`ifdef ROI_THRESHOLD_EN
      r_thr_en     <= 1'b0;
      r_thr        <= '0;
`endif
    end else begin
      src_en <= w_launch | w_issue;
      busy   <= (w_state_nxt != S_IDLE);
      done   <= w_empty_done | w_finish;

      if (w_launch) begin
        r_w          <= cfg_w;
        r_h          <= cfg_h;
        r_src_stride <= cfg_src_stride;
        r_dst_stride <= cfg_dst_stride;
        r_x          <= '0;
        r_y          <= '0;
        r_src_line   <= cfg_src_base;
        r_dst_line   <= cfg_dst_base;
        r_dst_cur    <= cfg_dst_base;
        src_addr     <= cfg_src_base;
`ifdef ROI_THRESHOLD_EN
        r_thr_en     <= cfg_thr_en;
        r_thr        <= cfg_thr;
`endif
      end else if (w_issue) begin
        if (w_line_end) begin
          // line change costs no cycle: jump straight to the next line base
          r_x        <= '0;
          r_y        <= r_y + c_one;
          r_src_line <= r_src_line + r_src_stride;
          r_dst_line <= r_dst_line + r_dst_stride;
          src_addr   <= r_src_line + r_src_stride;
          r_dst_cur  <= r_dst_line + r_dst_stride;
        end else begin
          r_x        <= r_x + c_one;
          src_addr   <= src_addr + c_one;
          r_dst_cur  <= r_dst_cur + c_one;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Write data path (optional binarisation, no extra latency)
  //--------------------------------------------------------------------------
  always_comb begin
    w_pix = src_data;
`ifdef ROI_THRESHOLD_EN
    if (r_thr_en) begin
      w_pix = (src_data >= r_thr) ? {DW{1'b1}} : {DW{1'b0}};
    end
`endif
  end

  //--------------------------------------------------------------------------
  // Latency pipe and destination port. Stage RD_LAT-1 is valid in the cycle
  // the BRAM presents data, so the write is registered one cycle later.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_apipe[i] <= '0;
      end
      dst_en   <= 1'b0;
      dst_we   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
    end else if (w_kill) begin
      // in-flight reads are dropped, never written
      r_vld  <= '0;
      dst_en <= 1'b0;
      dst_we <= 1'b0;
    end else begin
      r_vld[0]   <= src_en;
      r_apipe[0] <= r_dst_cur;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_apipe[i] <= r_apipe[i-1];
      end
      dst_en <= r_vld[RD_LAT-1];
      dst_we <= r_vld[RD_LAT-1];
      if (r_vld[RD_LAT-1]) begin
        dst_addr <= r_apipe[RD_LAT-1];
        dst_data <= w_pix;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_roi_copy.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
//  Module   : tb_image_roi_copy
//  Purpose  : Directed self-checking bench for image_roi_copy. Three DUT
//             instances (RD_LAT = 2, 1, 5) share one stimulus stream; each
//             has its own source BRAM model and write/read monitor.
//  Revision : 1.0  initial release
//============================================================================
module tb_image_roi_copy;

  localparam int AW    = 16;
  localparam int DW    = 4;
  localparam int NINST = 3;
  localparam int MAXN  = 64;

  typedef logic [AW-1:0] addr_arr_t [MAXN];
  typedef logic [DW-1:0] data_arr_t [MAXN];

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic          mon_clr = 1'b0;
  logic [AW-1:0] cfg_src_base   = '0;
  logic [AW-1:0] cfg_dst_base   = '0;
  logic [AW-1:0] cfg_src_stride = '0;
  logic [AW-1:0] cfg_dst_stride = '0;
  logic [AW-1:0] cfg_w          = '0;
  logic [AW-1:0] cfg_h          = '0;
`ifdef ROI_THRESHOLD_EN
  logic          cfg_thr_en     = 1'b0;
  logic [DW-1:0] cfg_thr        = '0;
`endif

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source frame content: XOR of the address nibbles.
  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12];
  endfunction

  //--------------------------------------------------------------------------
  // DUT instances, BRAM models and monitors
  //--------------------------------------------------------------------------
  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

    logic [AW-1:0] src_addr, dst_addr;
    logic [DW-1:0] src_data, dst_data;
    logic          src_en, dst_en, dst_we, busy, done;
    logic [DW-1:0] rd_pipe [LAT];

    int   wr_n, src_n, busy_n, done_n, run, run_max;
    int   first_src, first_we, last_we, done_at, enwe_err;
    logic busy_at_done;
    addr_arr_t wa, ra;
    data_arr_t wd;

    image_roi_copy #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .cfg_src_base   (cfg_src_base),
      .cfg_dst_base   (cfg_dst_base),
      .cfg_src_stride (cfg_src_stride),
      .cfg_dst_stride (cfg_dst_stride),
      .cfg_w          (cfg_w),
      .cfg_h          (cfg_h),
`ifdef ROI_THRESHOLD_EN
      .cfg_thr_en     (cfg_thr_en),
      .cfg_thr        (cfg_thr),
`endif
      .src_addr       (src_addr),
      .src_en         (src_en),
      .src_data       (src_data),
      .dst_addr       (dst_addr),
      .dst_data       (dst_data),
      .dst_en         (dst_en),
      .dst_we         (dst_we),
      .busy           (busy),
      .done           (done)
    );

    // Source BRAM with LAT cycles of read latency.
    always @(posedge clk) begin
      if (src_en) rd_pipe[0] <= pix(src_addr);
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign src_data = rd_pipe[LAT-1];

    always @(negedge clk) begin
      if (mon_clr) begin
        wr_n <= 0; src_n <= 0; busy_n <= 0; done_n <= 0; run <= 0; run_max <= 0;
        first_src <= -1; first_we <= -1; last_we <= -1; done_at <= -1;
        enwe_err <= 0; busy_at_done <= 1'b1;
      end else begin
        if (src_en) begin
          if (src_n < MAXN) ra[src_n] <= src_addr;
          if (src_n == 0) first_src <= cyc;
          src_n <= src_n + 1;
          run   <= run + 1;
          if (run + 1 > run_max) run_max <= run + 1;
        end else begin
          run <= 0;
        end
        if (dst_we) begin
          if (wr_n < MAXN) begin
            wa[wr_n] <= dst_addr;
            wd[wr_n] <= dst_data;
          end
          if (wr_n == 0) first_we <= cyc;
          last_we <= cyc;
          wr_n    <= wr_n + 1;
        end
        if (dst_en != dst_we) enwe_err <= enwe_err + 1;
        if (busy) busy_n <= busy_n + 1;
        if (done) begin
          done_n       <= done_n + 1;
          done_at      <= cyc;
          busy_at_done <= busy;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Helpers
  //--------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic set_cfg(input int sb, input int ss, input int db, input int ds,
                         input int w, input int h);
    cfg_src_base   = AW'(sb);
    cfg_src_stride = AW'(ss);
    cfg_dst_base   = AW'(db);
    cfg_dst_stride = AW'(ds);
    cfg_w          = AW'(w);
    cfg_h          = AW'(h);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!(g_dut[0].done_n > 0 && g_dut[1].done_n > 0 && g_dut[2].done_n > 0) && t < 400) begin
      tick(1);
      t++;
    end
    check({tag, "_timeout"}, (t < 400) ? 1 : 0, 1);
    tick(2);
  endtask

  // Compares the recorded writes of one instance against a raster walk.
  task automatic check_roi(input string tag, input int n, input addr_arr_t wa, input data_arr_t wd,
                           input int sb, input int ss, input int db, input int ds,
                           input int w, input int h);
    check({tag, "_count"}, n, w * h);
    for (int k = 0; k < w * h && k < n && k < MAXN; k++) begin
      logic [AW-1:0] sa, da;
      sa = AW'(sb + (k / w) * ss + (k % w));
      da = AW'(db + (k / w) * ds + (k % w));
      check($sformatf("%s_addr%0d", tag, k), 32'(wa[k]), 32'(da));
      check($sformatf("%s_data%0d", tag, k), 32'(wd[k]), 32'(pix(sa)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  initial begin
    logic [AW-1:0] wrap_exp [4];
    int k0, ca, cnt, t;
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // Reset state
    tick(3);
    check("rst_ctrl", 32'({g_dut[0].src_en, g_dut[0].dst_en, g_dut[0].dst_we,
                           g_dut[0].busy, g_dut[0].done}), 0);
    check("rst_src_addr", 32'(g_dut[0].src_addr), 0);
    check("rst_dst", 32'({g_dut[0].dst_addr, g_dut[0].dst_data}), 0);
    rst_n = 1'b1;
    tick(2);

    // Zero-size ROI: immediate done, nothing else
    clear_mon();
    set_cfg(16'h0100, 16, 16'h0200, 16, 0, 5);
    k0 = cyc;
    pulse_start();
    tick(4);
    check("zero_done_n", g_dut[0].done_n, 1);
    check("zero_done_at", g_dut[0].done_at, k0 + 1);
    check("zero_src_n", g_dut[0].src_n, 0);
    check("zero_wr_n", g_dut[0].wr_n, 0);
    check("zero_busy_n", g_dut[0].busy_n, 0);

    // Basic 4x3 copy; cfg scrambled and a stray start issued while busy
    clear_mon();
    set_cfg(0, 200, 1000, 4, 4, 3);
    pulse_start();
    set_cfg(16'h5555, 1, 16'h7777, 1, 9, 9);
    tick(3);
    pulse_start();
    wait_done("basic");
    check_roi("basic", g_dut[0].wr_n, g_dut[0].wa, g_dut[0].wd, 0, 200, 1000, 4, 4, 3);
    check("basic_lat", g_dut[0].first_we - g_dut[0].first_src, 3);
    check("basic_done_gap", g_dut[0].done_at - g_dut[0].last_we, 1);
    check("basic_done_n", g_dut[0].done_n, 1);
    check("basic_busy_at_done", 32'(g_dut[0].busy_at_done), 0);
    check("basic_src_n", g_dut[0].src_n, 12);
    check("basic_src_run", g_dut[0].run_max, 12);
    check("basic_busy_n", g_dut[0].busy_n, 15);
    check("basic_en_we", g_dut[0].enwe_err, 0);

    // Latency sweep 7x2 on the RD_LAT=1 and RD_LAT=5 instances
    clear_mon();
    set_cfg(16'h0100, 32, 16'h2000, 7, 7, 2);
    pulse_start();
    wait_done("sweep");
    check_roi("lat1", g_dut[1].wr_n, g_dut[1].wa, g_dut[1].wd, 16'h0100, 32, 16'h2000, 7, 7, 2);
    check_roi("lat5", g_dut[2].wr_n, g_dut[2].wa, g_dut[2].wd, 16'h0100, 32, 16'h2000, 7, 7, 2);
    check("lat1_src_run", g_dut[1].run_max, 14);
    check("lat5_src_run", g_dut[2].run_max, 14);
    check("lat1_lat", g_dut[1].first_we - g_dut[1].first_src, 2);
    check("lat5_lat", g_dut[2].first_we - g_dut[2].first_src, 6);
    check("lat1_done_gap", g_dut[1].done_at - g_dut[1].last_we, 1);
    check("lat5_done_gap", g_dut[2].done_at - g_dut[2].last_we, 1);

    // Address wrap-around
    clear_mon();
    set_cfg(16'hFFFE, 0, 16'h0010, 4, 4, 1);
    pulse_start();
    wait_done("wrap");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_rd%0d", k), 32'(g_dut[0].ra[k]), 32'(wrap_exp[k]));
    end
    check_roi("wrap", g_dut[0].wr_n, g_dut[0].wa, g_dut[0].wd, 16'hFFFE, 0, 16'h0010, 4, 4, 1);

    // Abort on the 5th read of a 10x10 copy
    clear_mon();
    set_cfg(0, 10, 16'h3000, 10, 10, 10);
    pulse_start();
    cnt = 0;
    t   = 0;
    while (cnt < 5 && t < 50) begin
      if (g_dut[0].src_en) cnt++;
      if (cnt < 5) begin
        tick(1);
        t++;
      end
    end
    check("abort_reach", cnt, 5);
    ca = cyc;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 32'(g_dut[0].busy), 0);
    check("abort_src_en", 32'(g_dut[0].src_en), 0);
    check("abort_dst_we", 32'(g_dut[0].dst_we), 0);
    tick(20);
    check("abort_wr_lat2", g_dut[0].wr_n, 2);
    check("abort_last_we", g_dut[0].last_we, ca);
    check("abort_wr_lat1", g_dut[1].wr_n, 3);
    check("abort_wr_lat5", g_dut[2].wr_n, 0);
    check("abort_done", g_dut[0].done_n + g_dut[1].done_n + g_dut[2].done_n, 0);

    // Fresh copy after abort
    clear_mon();
    set_cfg(16'h0040, 16, 16'h0050, 2, 2, 2);
    pulse_start();
    wait_done("fresh");
    check_roi("fresh", g_dut[0].wr_n, g_dut[0].wa, g_dut[0].wd, 16'h0040, 16, 16'h0050, 2, 2, 2);
    check("fresh_done_n", g_dut[0].done_n, 1);

    // abort together with start while idle: start ignored
    clear_mon();
    set_cfg(0, 3, 16'h0100, 3, 3, 3);
    abort = 1'b1;
    pulse_start();
    abort = 1'b0;
    tick(6);
    check("abst_src_n", g_dut[0].src_n, 0);
    check("abst_busy_n", g_dut[0].busy_n, 0);
    check("abst_done_n", g_dut[0].done_n, 0);

`ifdef ROI_THRESHOLD_EN
    // Binarisation: source pixels 7, 8, 15, 1 against threshold 8
    clear_mon();
    cfg_thr_en = 1'b1;
    cfg_thr    = 4'd8;
    set_cfg(7, 8, 16'h0030, 2, 2, 2);
    pulse_start();
    cfg_thr = 4'd0;
    wait_done("thr");
    check("thr_count", g_dut[0].wr_n, 4);
    check("thr_d0", 32'(g_dut[0].wd[0]), 32'h0);
    check("thr_d1", 32'(g_dut[0].wd[1]), 32'hF);
    check("thr_d2", 32'(g_dut[0].wd[2]), 32'hF);
    check("thr_d3", 32'(g_dut[0].wd[3]), 32'h0);
    cfg_thr_en = 1'b0;
`endif

    // Asynchronous reset in the middle of a copy
    clear_mon();
    set_cfg(0, 10, 16'h3000, 10, 10, 10);
    pulse_start();
    tick(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 32'({g_dut[0].src_en, g_dut[0].dst_en, g_dut[0].dst_we,
                            g_dut[0].busy, g_dut[0].done}), 0);
    check("arst_addr", 32'({g_dut[0].src_addr, g_dut[0].dst_addr}), 0);
    tick(1);
    rst_n = 1'b1;
    tick(30);
    check("arst_done_n", g_dut[0].done_n, 0);
    check("arst_idle", 32'({g_dut[0].src_en, g_dut[0].busy}), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
